// File: rtl/snr_meter_pkg.sv
// Shared state type, fixed-point constants and the Q8 log2 helper for snr_meter.
package snr_meter_pkg;

    typedef enum logic {
        CALIB = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned LOG_FRAC       = 8;
    localparam int unsigned DB_PER_LOG2_Q8 = 1541;

    // Integer part is the msb index; the fraction is the 8 bits below the msb, zero-padded.
    function automatic logic [15:0] log2_q8(input logic [31:0] x);
        logic [4:0] msb;
        logic [7:0] frac;
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) msb = 5'(i);
        end
        frac = 8'((x << (5'd31 - msb)) >> (31 - LOG_FRAC));
        if (x == '0) log2_q8 = '0;
        else         log2_q8 = {3'b000, msb, frac};
    endfunction

endpackage

// File: rtl/snr_ema.sv
// One exponential moving-average magnitude filter, unsigned Q.16 accumulator.
module snr_ema
    import snr_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   update,
    input  logic                   stall,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [WIDTH-1:0]       mag,
    output logic [WIDTH-1:0]       rms
);
    localparam int unsigned AW = WIDTH + 16;

    logic [AW-1:0]        acc;
    logic signed [AW:0]   diff;
    logic [AW-1:0]        acc_next;

    // The step always moves acc toward mag<<16, so the sum can neither wrap nor go negative.
    always_comb begin
        diff     = $signed({1'b0, mag, 16'h0000}) - $signed({1'b0, acc});
        acc_next = acc + AW'(diff >>> shift);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (update && !stall) begin
            acc <= acc_next;
        end
    end

    assign rms = acc[AW-1:16];

endmodule

// File: rtl/snr_meter.sv
// Streaming SNR meter: two EMA magnitude filters, calibration FSM, 3-stage log/dB pipeline.
// Optional peak hold of emitted snr_db is enabled by defining SNR_METER_PEAK_HOLD_EN.
module snr_meter
    import snr_meter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SNR_WIDTH   = 16,
    parameter int unsigned SIG_SHIFT   = 2,
    parameter int unsigned NOISE_SHIFT = 7,
    parameter int unsigned CAL_SAMPLES = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        quiet_period,
    input  logic                        recal,
    input  logic [DATA_WIDTH-1:0]       audio_input,
    input  logic                        audio_input_valid,
    output logic                        audio_input_ready,
    output logic signed [SNR_WIDTH-1:0] snr_db,
    output logic [DATA_WIDTH-1:0]       signal_rms,
    output logic [DATA_WIDTH-1:0]       noise_rms,
    output logic                        calibrated,
    output logic                        output_valid,
    input  logic                        output_ready
`ifdef SNR_METER_PEAK_HOLD_EN
    ,
    input  logic                        peak_clr,
    output logic signed [SNR_WIDTH-1:0] snr_peak
`endif
);
    localparam int unsigned CNT_W   = $clog2(CAL_SAMPLES + 1);
    localparam int          SNR_MAX_I = (1 << (SNR_WIDTH - 1)) - 1;
    localparam int          SNR_MIN_I = -(1 << (SNR_WIDTH - 1));
    localparam logic signed [SNR_WIDTH-1:0] SNR_MAX = {1'b0, {(SNR_WIDTH-1){1'b1}}};
    localparam logic signed [SNR_WIDTH-1:0] SNR_MIN = {1'b1, {(SNR_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]       MAG_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic                  stall, accept, calib_mode, noise_upd;
    logic [4:0]            noise_shift;
    logic [DATA_WIDTH-1:0] mag, sig_rms0, noise_rms0;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign stall             = output_valid && !output_ready;
    assign accept            = audio_input_valid && !stall;
    assign audio_input_ready = !stall;

    always_comb begin
        if (!audio_input[DATA_WIDTH-1])            mag = audio_input;
        else if (audio_input[DATA_WIDTH-2:0] == '0) mag = MAG_MAX;
        else                                        mag = -audio_input;
    end

    // A recal sample is treated as a calibration sample for the noise filter.
    assign calib_mode  = recal || (state_q == CALIB);
    assign noise_upd   = accept && (calib_mode || quiet_period);
    assign noise_shift = calib_mode ? 5'(SIG_SHIFT) : 5'(NOISE_SHIFT);

    snr_ema #(.WIDTH(DATA_WIDTH), .SHIFT_WIDTH(5)) u_sig_ema (
        .clk   (clk),
        .reset (reset),
        .update(accept),
        .stall (stall),
        .shift (5'(SIG_SHIFT)),
        .mag   (mag),
        .rms   (sig_rms0)
    );

    snr_ema #(.WIDTH(DATA_WIDTH), .SHIFT_WIDTH(5)) u_noise_ema (
        .clk   (clk),
        .reset (reset),
        .update(noise_upd),
        .stall (stall),
        .shift (noise_shift),
        .mag   (mag),
        .rms   (noise_rms0)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (recal) begin
            state_d = CALIB;
            cnt_d   = '0;
        end else if (accept && state_q == CALIB) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(CAL_SAMPLES)) state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CALIB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic                  e0_valid, e0_cal, e1_valid, e1_cal;
    logic [15:0]           e1_lsig, e1_lnoise;
    logic [DATA_WIDTH-1:0] e1_sig, e1_noise;
    logic signed [31:0]    ldiff, prod, scaled;
    logic signed [SNR_WIDTH-1:0] snr_next;

    always_comb begin
        ldiff  = $signed({16'h0000, e1_lsig}) - $signed({16'h0000, e1_lnoise});
        prod   = ldiff * $signed(DB_PER_LOG2_Q8);
        scaled = prod >>> 16;
        if (scaled > SNR_MAX_I)      snr_next = SNR_MAX;
        else if (scaled < SNR_MIN_I) snr_next = SNR_MIN;
        else                         snr_next = scaled[SNR_WIDTH-1:0];
        if (e1_noise == '0) snr_next = (e1_sig != '0) ? SNR_MAX : '0;
    end

    // Stage data only loads behind a valid, so outputs keep the last emitted sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            e0_valid     <= 1'b0;
            e0_cal       <= 1'b0;
            e1_valid     <= 1'b0;
            e1_cal       <= 1'b0;
            e1_lsig      <= '0;
            e1_lnoise    <= '0;
            e1_sig       <= '0;
            e1_noise     <= '0;
            output_valid <= 1'b0;
            snr_db       <= '0;
            signal_rms   <= '0;
            noise_rms    <= '0;
            calibrated   <= 1'b0;
        end else if (!stall) begin
            e0_valid     <= accept;
            e1_valid     <= e0_valid;
            output_valid <= e1_valid;
            if (accept) e0_cal <= (state_d == RUN);
            if (e0_valid) begin
                e1_cal    <= e0_cal;
                e1_sig    <= sig_rms0;
                e1_noise  <= noise_rms0;
                e1_lsig   <= log2_q8(32'(sig_rms0));
                e1_lnoise <= log2_q8(32'(noise_rms0));
            end
            if (e1_valid) begin
                snr_db     <= snr_next;
                signal_rms <= e1_sig;
                noise_rms  <= e1_noise;
                calibrated <= e1_cal;
            end
        end
    end

`ifdef SNR_METER_PEAK_HOLD_EN
    logic xfer, peak_reset;
    assign xfer       = output_valid && output_ready;
    assign peak_reset = peak_clr || recal;

    always_ff @(posedge clk) begin
        if (reset) begin
            snr_peak <= SNR_MIN;
        end else if (xfer && (peak_reset || snr_db > snr_peak)) begin
            snr_peak <= snr_db;
        end else if (peak_reset) begin
            snr_peak <= SNR_MIN;
        end
    end
`endif

endmodule
